// File: rtl/debug_word_tx.sv
// debug_word_tx: serialises 32-bit debug words as four back-to-back UART frames, LSB byte first.
// Define DEBUG_TX_PARITY_EN to add an even-parity bit to every frame. Rev 1.0
`default_nettype none

module debug_word_tx #(
   parameter int CLKS_PER_BIT   = 5208,
   parameter int BYTES_PER_WORD = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] tx_word,
   input  logic        tx_word_valid,
   output logic        tx_word_ready,
   output logic        tx_done,
   output logic        tx_busy,
   output logic        uart_tx
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  baud_cnt;
   logic [2:0]        bit_idx;
   logic [1:0]        byte_idx;
   logic [7:0]        shift_reg;
   logic [23:0]       word_reg;
   logic              bit_end;
`ifdef DEBUG_TX_PARITY_EN
   logic              parity_bit;
`endif

   assign bit_end = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         baud_cnt      <= '0;
         bit_idx       <= 3'd0;
         byte_idx      <= 2'd0;
         shift_reg     <= 8'h00;
         word_reg      <= 24'h000000;
         uart_tx       <= 1'b1;
         tx_word_ready <= 1'b1;
         tx_busy       <= 1'b0;
         tx_done       <= 1'b0;
`ifdef DEBUG_TX_PARITY_EN
         parity_bit    <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               baud_cnt <= '0;
               if (tx_word_valid) begin
                  // Byte 0 goes straight into the shifter; the rest wait in word_reg.
                  shift_reg     <= tx_word[7:0];
                  word_reg      <= tx_word[31:8];
`ifdef DEBUG_TX_PARITY_EN
                  parity_bit    <= ^tx_word[7:0];
`endif
                  bit_idx       <= 3'd0;
                  byte_idx      <= 2'd0;
                  uart_tx       <= 1'b0;
                  tx_word_ready <= 1'b0;
                  tx_busy       <= 1'b1;
                  state         <= ST_START;
               end
            end

            ST_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= 3'd0;
                  uart_tx  <= shift_reg[0];
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  baud_cnt  <= '0;
                  shift_reg <= shift_reg >> 1;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= 3'd0;
`ifdef DEBUG_TX_PARITY_EN
                     uart_tx <= parity_bit;
                     state   <= ST_PARITY;
`else
                     uart_tx <= 1'b1;
                     state   <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

`ifdef DEBUG_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  uart_tx  <= 1'b1;
                  state    <= ST_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif

            ST_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (byte_idx == LAST_BYTE) begin
                     tx_done <= 1'b1;
                     state   <= ST_DONE;
                  end else begin
                     // Next start bit follows the stop bit with no idle gap.
                     byte_idx   <= byte_idx + 2'd1;
                     shift_reg  <= word_reg[7:0];
                     word_reg   <= {8'h00, word_reg[23:8]};
`ifdef DEBUG_TX_PARITY_EN
                     parity_bit <= ^word_reg[7:0];
`endif
                     uart_tx    <= 1'b0;
                     state      <= ST_START;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            ST_DONE: begin
               byte_idx      <= 2'd0;
               tx_word_ready <= 1'b1;
               tx_busy       <= 1'b0;
               uart_tx       <= 1'b1;
               state         <= ST_IDLE;
            end

            default: begin
               baud_cnt      <= '0;
               bit_idx       <= 3'd0;
               byte_idx      <= 2'd0;
               tx_word_ready <= 1'b1;
               tx_busy       <= 1'b0;
               uart_tx       <= 1'b1;
               state         <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_debug_word_tx.sv
// Bench for debug_word_tx at CLKS_PER_BIT=4: a line monitor decodes frames against a byte scoreboard.
`default_nettype none

module tb_debug_word_tx;

   localparam int CPB = 4;
`ifdef DEBUG_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int WORD_CYC = FRAME_BITS * 4 * CPB;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] tx_word = 32'h0;
   logic        tx_word_valid = 1'b0;
   logic        tx_word_ready;
   logic        tx_done;
   logic        tx_busy;
   logic        uart_tx;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];

   debug_word_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk           (clk),
      .reset         (reset),
      .tx_word       (tx_word),
      .tx_word_valid (tx_word_valid),
      .tx_word_ready (tx_word_ready),
      .tx_done       (tx_done),
      .tx_busy       (tx_busy),
      .uart_tx       (uart_tx)
   );

   always #5 clk = ~clk;

   // Line monitor: samples each bit mid-way, decodes and scores complete frames.
   bit         mon_active = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_byte = 8'h00;
   logic       mon_par = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         mon_active = 1'b0;
         exp_q.delete();
      end else if (!mon_active) begin
         if (uart_tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % CPB == CPB / 2) begin
            automatic int k = mon_cnt / CPB;
            if (k == 0) begin
               checks++;
               if (uart_tx !== 1'b0) begin
                  errors++;
                  $display("FAIL start_bit: line=%b required 0", uart_tx);
               end
            end else if (k <= 8) begin
               mon_byte[k-1] = uart_tx;
            end else if (k < FRAME_BITS - 1) begin
               mon_par = uart_tx;
            end else begin
               mon_active = 1'b0;
               checks++;
               if (uart_tx !== 1'b1) begin
                  errors++;
                  $display("FAIL stop_bit: line=%b required 1", uart_tx);
               end
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_frame: got byte %02h, required no frame", mon_byte);
               end else begin
                  automatic logic [7:0] e = exp_q.pop_front();
                  if (mon_byte !== e) begin
                     errors++;
                     $display("FAIL frame_byte: got %02h required %02h", mon_byte, e);
                  end
`ifdef DEBUG_TX_PARITY_EN
                  checks++;
                  if (mon_par !== ^e) begin
                     errors++;
                     $display("FAIL parity_bit: got %b required %b for byte %02h", mon_par, ^e, e);
                  end
`endif
               end
            end
         end
      end
   end

   // Called at a negedge; leaves the caller at the negedge of the start-bit cycle.
   task automatic send_word(input logic [31:0] w);
      checks++;
      if (tx_word_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready: ready=%b required 1", tx_word_ready);
      end
      tx_word       = w;
      tx_word_valid = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
      @(posedge clk);
      #1 tx_word_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b0 || tx_busy !== 1'b1 || tx_word_ready !== 1'b0) begin
         errors++;
         $display("FAIL start_latency: line=%b busy=%b ready=%b required 0 1 0",
                  uart_tx, tx_busy, tx_word_ready);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 1000) begin
         @(negedge clk);
         n++;
         if (tx_done === 1'b1) break;
      end
      if (n >= 1000) begin
         errors++;
         $display("FAIL done_timeout: no tx_done within %0d cycles", n);
      end
   endtask

   task automatic check_word_end(input string name, input int n);
      checks++;
      if (n != WORD_CYC) begin
         errors++;
         $display("FAIL %s_done_cycle: tx_done at %0d required %0d", name, n, WORD_CYC);
      end
      @(negedge clk);
      checks++;
      if (tx_done !== 1'b0 || tx_word_ready !== 1'b1 || tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL %s_after_done: done=%b ready=%b busy=%b line=%b required 0 1 0 1",
                  name, tx_done, tx_word_ready, tx_busy, uart_tx);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_bytes_left: %0d undecoded bytes required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset;
      int bad;
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1 || tx_word_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: line=%b ready=%b busy=%b done=%b required 1 1 0 0",
                  uart_tx, tx_word_ready, tx_busy, tx_done);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || tx_word_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle_hold: %0d bad idle cycles required 0", bad);
      end
   endtask

   task automatic test_single;
      int n;
      send_word(32'h12345678);
      wait_done(n);
      check_word_end("single", n);
   endtask

   task automatic test_back_to_back;
      int n;
      tx_word       = 32'hFFFFFFFF;
      tx_word_valid = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
      @(posedge clk);
      #1 tx_word = 32'h00000000;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first_start: line=%b required 0", uart_tx);
      end
      wait_done(n);
      checks++;
      if (n != WORD_CYC) begin
         errors++;
         $display("FAIL b2b_first_done: tx_done at %0d required %0d", n, WORD_CYC);
      end
      @(negedge clk);
      checks++;
      if (tx_word_ready !== 1'b1 || uart_tx !== 1'b1 || tx_done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: ready=%b line=%b done=%b required 1 1 0",
                  tx_word_ready, uart_tx, tx_done);
      end
      @(posedge clk);
      #1 tx_word_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b0 || tx_busy !== 1'b1 || tx_word_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_accept: line=%b busy=%b ready=%b required 0 1 0",
                  uart_tx, tx_busy, tx_word_ready);
      end
      wait_done(n);
      check_word_end("b2b", n);
   endtask

   task automatic test_ignore_busy;
      int n;
      int bad;
      send_word(32'h13579BDF);
      repeat (30) @(negedge clk);
      tx_word       = 32'hDEADBEEF;
      tx_word_valid = 1'b1;
      @(negedge clk);
      tx_word_valid = 1'b0;
      wait_done(n);
      n = n + 31;
      check_word_end("ignore", n);
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ignore_extra_frame: %0d non-idle cycles required 0", bad);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      int bad;
      send_word(32'hA5A5A5A5);
      // Byte 2 starts 80 cycles in; its d3 bit spans cycles 96..99.
      repeat (96) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checks++;
      if (tx_done !== 1'b0) begin
         errors++;
         $display("FAIL midreset_done_pre: done=%b required 0", tx_done);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1 || tx_word_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         errors++;
         $display("FAIL midreset_state: line=%b ready=%b busy=%b done=%b required 1 1 0 0",
                  uart_tx, tx_word_ready, tx_busy, tx_done);
      end
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx_done !== 1'b0 || uart_tx !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midreset_quiet: %0d bad cycles required 0", bad);
      end
      send_word(32'h0000003C);
      wait_done(n);
      check_word_end("post_reset", n);
   endtask

`ifdef DEBUG_TX_PARITY_EN
   task automatic test_parity;
      int n;
      send_word(32'h00000107);
      wait_done(n);
      check_word_end("parity", n);
   endtask
`endif

   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      test_single();
      @(negedge clk);
      test_back_to_back();
      @(negedge clk);
      test_ignore_busy();
      test_reset_mid();
`ifdef DEBUG_TX_PARITY_EN
      @(negedge clk);
      test_parity();
`endif
      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
